ps2_ace_keyboard: RTL and testbench

PS2_ACE_KEYBOARD -- requirements
Module: ps2_ace_keyboard

---
 rtl/ps2_ace_keyboard.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_ace_keyboard.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ps2_ace_keyboard.sv
// ps2_ace_keyboard: PS/2 receiver + scan-code decoder driving the Jupiter Ace 8x5 key matrix.
// Rev 1.0 -- initial release.
`default_nettype none

module ps2_ace_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 13000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] filas,
  output logic [4:0] columnas,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXTBRK = 2'd3} state_t;

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
  logic            filt_q, filt_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            frame_err_q, frame_err_d;
  state_t          state_q, state_d;
  logic [39:0]     matrix_q, matrix_d;
  logic            shl_q, shl_d, shr_q, shr_d;
  logic            key_strobe_q, key_strobe_d;
  logic            fall;

  // Returns {valid, index} where index = row*5 + col; the two SHIFT codes are handled separately.
  function automatic logic [6:0] map_code(input logic [7:0] code, input logic ext);
    logic [6:0] m;
    m = 7'd0;
    if (ext) begin
      case (code)
        8'h5A: m = {1'b1, 6'd30};
        8'h14: m = {1'b1, 6'd1};
        default: m = 7'd0;
      endcase
    end else begin
      case (code)
        8'h14: m = {1'b1, 6'd1};  8'h1A: m = {1'b1, 6'd2};  8'h22: m = {1'b1, 6'd3};  8'h21: m = {1'b1, 6'd4};
        8'h1C: m = {1'b1, 6'd5};  8'h1B: m = {1'b1, 6'd6};  8'h23: m = {1'b1, 6'd7};  8'h2B: m = {1'b1, 6'd8};
        8'h34: m = {1'b1, 6'd9};  8'h15: m = {1'b1, 6'd10}; 8'h1D: m = {1'b1, 6'd11}; 8'h24: m = {1'b1, 6'd12};
        8'h2D: m = {1'b1, 6'd13}; 8'h2C: m = {1'b1, 6'd14}; 8'h16: m = {1'b1, 6'd15}; 8'h1E: m = {1'b1, 6'd16};
        8'h26: m = {1'b1, 6'd17}; 8'h25: m = {1'b1, 6'd18}; 8'h2E: m = {1'b1, 6'd19}; 8'h45: m = {1'b1, 6'd20};
        8'h46: m = {1'b1, 6'd21}; 8'h3E: m = {1'b1, 6'd22}; 8'h3D: m = {1'b1, 6'd23}; 8'h36: m = {1'b1, 6'd24};
        8'h4D: m = {1'b1, 6'd25}; 8'h44: m = {1'b1, 6'd26}; 8'h43: m = {1'b1, 6'd27}; 8'h3C: m = {1'b1, 6'd28};
        8'h35: m = {1'b1, 6'd29}; 8'h5A: m = {1'b1, 6'd30}; 8'h4B: m = {1'b1, 6'd31}; 8'h42: m = {1'b1, 6'd32};
        8'h3B: m = {1'b1, 6'd33}; 8'h33: m = {1'b1, 6'd34}; 8'h29: m = {1'b1, 6'd35}; 8'h3A: m = {1'b1, 6'd36};
        8'h31: m = {1'b1, 6'd37}; 8'h32: m = {1'b1, 6'd38}; 8'h2A: m = {1'b1, 6'd39};
        default: m = 7'd0;
      endcase
    end
    return m;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      flt_cnt_q    <= '0;
      filt_q       <= 1'b1;
      bitcnt_q     <= 4'd0;
      shift_q      <= 10'd0;
      idle_q       <= '0;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= 8'd0;
      frame_err_q  <= 1'b0;
      state_q      <= IDLE;
      matrix_q     <= 40'd0;
      shl_q        <= 1'b0;
      shr_q        <= 1'b0;
      key_strobe_q <= 1'b0;
    end else begin
      clk_s1_q     <= ps2clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2data;
      dat_s2_q     <= dat_s1_q;
      flt_cnt_q    <= flt_cnt_d;
      filt_q       <= filt_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      rx_valid_q   <= rx_valid_d;
      rx_byte_q    <= rx_byte_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      matrix_q     <= matrix_d;
      shl_q        <= shl_d;
      shr_q        <= shr_d;
      key_strobe_q <= key_strobe_d;
    end
  end

  // Glitch filter: the FILTER_LEN-th consecutive differing sample flips the level.
  always_comb begin
    flt_cnt_d = '0;
    filt_d    = filt_q;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == FLT_MAX) filt_d = clk_s2_q;
      else flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  // Bits 0..9 (start, data, parity) shift in from the top; the stop bit is checked live.
  always_comb begin
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    idle_d      = idle_q;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_q;
    frame_err_d = 1'b0;
    if (fall) begin
      idle_d = '0;
      if (bitcnt_q == 4'd10) begin
        bitcnt_d = 4'd0;
        if (!shift_q[0] && (^shift_q[9:1]) && dat_s2_q) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d  = {dat_s2_q, shift_q[9:1]};
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != 4'd0) begin
      if (idle_q == TO_MAX) begin
        bitcnt_d = 4'd0;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_comb begin
    logic [6:0] m;
    logic       do_key, key_set, key_ext;
    state_d  = state_q;
    shl_d    = shl_q;
    shr_d    = shr_q;
    matrix_d = matrix_q;
    do_key   = 1'b0;
    key_set  = 1'b0;
    key_ext  = 1'b0;
    m        = 7'd0;
    if (rx_valid_q) begin
      if (rx_byte_q == 8'h00 || rx_byte_q == 8'hFF) begin
        state_d  = IDLE;
        shl_d    = 1'b0;
        shr_d    = 1'b0;
        matrix_d = 40'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_byte_q == 8'hE0) state_d = EXT;
            else if (rx_byte_q == 8'hF0) state_d = BRK;
            else if (rx_byte_q != 8'hAA && rx_byte_q != 8'hFA &&
                     rx_byte_q != 8'hEE && rx_byte_q != 8'hFE) begin
              do_key  = 1'b1;
              key_set = 1'b1;
            end
          end
          EXT: begin
            if (rx_byte_q == 8'hF0) state_d = EXTBRK;
            else begin
              do_key  = 1'b1;
              key_set = 1'b1;
              key_ext = 1'b1;
              state_d = IDLE;
            end
          end
          BRK: begin
            do_key  = 1'b1;
            state_d = IDLE;
          end
          default: begin
            do_key  = 1'b1;
            key_ext = 1'b1;
            state_d = IDLE;
          end
        endcase
        if (do_key) begin
          if (!key_ext && rx_byte_q == 8'h12) shl_d = key_set;
          else if (!key_ext && rx_byte_q == 8'h59) shr_d = key_set;
          else begin
            m = map_code(rx_byte_q, key_ext);
            if (m[6]) matrix_d[m[5:0]] = key_set;
          end
        end
      end
    end
    // SHIFT is the OR of both physical shift keys.
    matrix_d[0]  = shl_d | shr_d;
    key_strobe_d = (matrix_d != matrix_q);
  end

  always_comb begin
    columnas = 5'h1F;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 8; r++) begin
        if (!filas[r] && matrix_q[r*5 + c]) columnas[c] = 1'b0;
      end
    end
  end

  assign key_strobe = key_strobe_q;
  assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_ace_keyboard.sv
// Directed bench for ps2_ace_keyboard: bit-banged PS/2 frames, checks on the matrix and pulses.
`default_nettype none

module tb_ps2_ace_keyboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] filas = 8'hFF;
  logic [4:0] columnas;
  logic       key_strobe;
  logic       frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int ks_cnt = 0;
  int fe_cnt = 0;
  int ks0, fe0;

  ps2_ace_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(300)) dut (
    .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
    .filas(filas), .columnas(columnas), .key_strobe(key_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_strobe) ks_cnt <= ks_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2data = b;
    repeat (20) @(negedge clk);
    ps2clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par = 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (40) @(negedge clk);
  endtask

  task automatic cols(input string tag, input logic [7:0] f, input logic [4:0] exp);
    @(negedge clk) filas = f;
    #1 check(tag, columnas, exp);
  endtask

  task automatic mark;
    ks0 = ks_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    filas = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cols", columnas, 5'h1F);
    check("rst_strobe", key_strobe, 0);
    check("rst_ferr", frame_err, 0);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_cols", columnas, 5'h1F);

    mark();
    send(8'h1C);
    cols("make_A", 8'hFD, 5'h1E);
    check("make_A_strobe", ks_cnt - ks0, 1);
    mark();
    send(8'hF0); send(8'h1C);
    cols("brk_A", 8'hFD, 5'h1F);
    check("brk_A_strobe", ks_cnt - ks0, 1);

    mark();
    send(8'h1A, 1'b1);
    check("par_ferr", fe_cnt - fe0, 1);
    check("par_strobe", ks_cnt - ks0, 0);
    cols("par_matrix", 8'hFE, 5'h1F);

    mark();
    send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
    cols("shift_held", 8'hFE, 5'h1E);
    check("shift_strobe", ks_cnt - ks0, 1);
    send(8'hF0); send(8'h59);
    cols("shift_rel", 8'hFE, 5'h1F);

    mark();
    send(8'hE0); send(8'h5A);
    cols("ext_enter", 8'hBF, 5'h1E);
    check("ext_enter_strobe", ks_cnt - ks0, 1);
    mark();
    send(8'hE0); send(8'h75);
    check("ext_unmapped_strobe", ks_cnt - ks0, 0);
    cols("ext_unmapped", 8'hBF, 5'h1E);
    send(8'hE0); send(8'h14);
    cols("ext_symsh", 8'hFE, 5'h1D);
    mark();
    send(8'hAA); send(8'h76);
    check("ignored_strobe", ks_cnt - ks0, 0);

    send(8'h16); send(8'h3A);
    cols("two_rows", 8'h77, 5'h1C);
    cols("row6_enter", 8'hBF, 5'h1E);
    send(8'hFF);
    cols("overrun", 8'h00, 5'h1F);

    mark();
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    repeat (400) @(negedge clk);
    send(8'h29);
    check("timeout_ferr", fe_cnt - fe0, 0);
    cols("timeout_space", 8'h7F, 5'h1E);

    for (int i = 0; i < 4; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    @(negedge clk) reset = 1'b1;
    filas = 8'h00;
    repeat (3) @(negedge clk);
    check("midrst_cols", columnas, 5'h1F);
    check("midrst_strobe", key_strobe, 0);
    @(negedge clk) reset = 1'b0;
    repeat (20) @(negedge clk);
    mark();
    send(8'h35);
    cols("midrst_Y", 8'hDF, 5'h0F);
    cols("midrst_space_gone", 8'h7F, 5'h1F);
    check("midrst_ferr", fe_cnt - fe0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
